// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Execution unit driven by the 4-bit ALU operation code. Single-step ops
//   (ADD/SUB/AND/OR/XOR/SLL/SRL/LUI) finish in one cycle. Unsigned
//   MUL/MULHU/DIVU/REMU iterate for WIDTH cycles, one bit per cycle.
//   A valid/ready/done handshake lets the datapath stall while an op runs.
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   valid_i          operation request, accepted when ready_o is high
//   ALU_Operation_i  op code, sampled on acceptance
//   A_i, B_i         operands, sampled on acceptance
//   flush_i          synchronous abort of an in-flight op
//   ready_o          unit is idle and can accept a request
//   done_o           one-cycle pulse, result_o/zero_o/illegal_o are valid
//   result_o         result, held until the next done_o
//   zero_o           result_o == 0, updated with done_o
//   illegal_o        op code was unsupported, updated with done_o
module multicycle_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic [3:0]       ALU_Operation_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             flush_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             illegal_o
);

   localparam int unsigned SH_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLL   = 4'b0101,
      OP_SRL   = 4'b0110,
      OP_LUI   = 4'b0111,
      OP_MUL   = 4'b1000,
      OP_MULHU = 4'b1001,
      OP_DIVU  = 4'b1010,
      OP_REMU  = 4'b1011
   } op_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;

   // Iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quot_next;
   logic [SH_W-1:0]    shamt;

   always_comb begin
      // Shift-add: the multiplier lives in the low half of acc and is
      // consumed LSB first while the partial product shifts in from the top.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      // Restoring division: shifted remainder needs one extra bit.
      div_shift = {rem_q, quot_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_diff  = div_shift - {1'b0, b_q};
      rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quot_next = {quot_q[WIDTH-2:0], div_ge};
      shamt     = B_i[SH_W-1:0];

      state_d   = state_q;
      op_d      = op_q;
      b_d       = b_q;
      acc_d     = acc_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;

      unique case (state_q)
         S_IDLE: begin
            if (!flush_i && valid_i) begin
               op_d      = ALU_Operation_i;
               b_d       = B_i;
               cnt_d     = '0;
               illegal_d = 1'b0;
               state_d   = S_DONE;
               case (ALU_Operation_i)
                  OP_ADD: result_d = A_i + B_i;
                  OP_SUB: result_d = A_i - B_i;
                  OP_AND: result_d = A_i & B_i;
                  OP_OR:  result_d = A_i | B_i;
                  OP_XOR: result_d = A_i ^ B_i;
                  OP_SLL: result_d = A_i << shamt;
                  OP_SRL: result_d = A_i >> shamt;
                  OP_LUI: result_d = B_i;
                  OP_MUL, OP_MULHU: begin
                     acc_d   = {{WIDTH{1'b0}}, A_i};
                     state_d = S_ITER;
                  end
                  OP_DIVU, OP_REMU: begin
                     if (B_i == '0) begin
                        result_d = (ALU_Operation_i == OP_DIVU) ? '1 : A_i;
                     end else begin
                        quot_d  = A_i;
                        rem_d   = '0;
                        state_d = S_ITER;
                     end
                  end
                  default: begin
                     result_d  = '0;
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end
         S_ITER: begin
            if (flush_i) begin
               state_d   = S_IDLE;
               illegal_d = illegal_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[1]) begin
                  quot_d = quot_next;
                  rem_d  = rem_next;
               end else begin
                  acc_d = mul_next;
               end
               if (cnt_q == CNT_W'(WIDTH-1)) begin
                  state_d   = S_DONE;
                  illegal_d = 1'b0;
                  case (op_q)
                     OP_MUL:   result_d = mul_next[WIDTH-1:0];
                     OP_MULHU: result_d = mul_next[2*WIDTH-1:WIDTH];
                     OP_DIVU:  result_d = quot_next;
                     default:  result_d = rem_next;
                  endcase
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flags register only on the edge entering DONE.
      if (state_q != S_DONE && state_d == S_DONE) begin
         zero_d = (result_d == '0);
      end

      ready_d = (state_d == S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign ready_o   = ready_q;
   assign done_o    = done_q;
   assign result_o  = result_q;
   assign zero_o    = zero_q;
   assign illegal_o = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
//   Directed bench for multicycle_alu with hand-computed expected values.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_i = 1'b0;
   logic [3:0]  ALU_Operation_i = '0;
   logic [31:0] A_i = '0;
   logic [31:0] B_i = '0;
   logic        flush_i = 1'b0;
   logic        ready_o, done_o, zero_o, illegal_o;
   logic [31:0] result_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i),
      .ALU_Operation_i(ALU_Operation_i), .A_i(A_i), .B_i(B_i),
      .flush_i(flush_i), .ready_o(ready_o), .done_o(done_o),
      .result_o(result_o), .zero_o(zero_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   // Issue one request and wait (bounded) for done_o; lat counts falling
   // edges after the accept edge, so a single-step op gives 1.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
      int w = 0;
      @(negedge clk);
      while (!ready_o && w < 50) begin
         @(negedge clk);
         w++;
      end
      valid_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
      @(posedge clk);
      #1 valid_i = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done_o) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) lat = 999;
   endtask

   task automatic test_reset();
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else pass_cnt++;
      total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_o); else pass_cnt++;
      total_cnt++; if (result_o !== 32'h0) $display("FAIL reset_result got=%h exp=0", result_o); else pass_cnt++;
      total_cnt++; if (zero_o !== 1'b1) $display("FAIL reset_zero got=%b exp=1", zero_o); else pass_cnt++;
      total_cnt++; if (illegal_o !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal_o); else pass_cnt++;
   endtask

   task automatic test_add();
      int lat;
      run_op(4'b0000, 32'h7FFF_FFFF, 32'h1, lat);
      total_cnt++; if (lat !== 1) $display("FAIL add_latency got=%0d exp=1", lat); else pass_cnt++;
      total_cnt++; if (result_o !== 32'h8000_0000) $display("FAIL add_result got=%h exp=80000000", result_o); else pass_cnt++;
      total_cnt++; if (zero_o !== 1'b0) $display("FAIL add_zero got=%b exp=0", zero_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b0) $display("FAIL add_ready_in_done got=%b exp=0", ready_o); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      @(negedge clk);
      valid_i = 1'b1; ALU_Operation_i = 4'b0001; A_i = 32'd5; B_i = 32'd5;
      @(posedge clk);
      @(negedge clk);
      total_cnt++; if (done_o !== 1'b1) $display("FAIL b2b_done1 got=%b exp=1", done_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b0) $display("FAIL b2b_ready_done got=%b exp=0", ready_o); else pass_cnt++;
      total_cnt++; if (result_o !== 32'h0) $display("FAIL sub_result got=%h exp=0", result_o); else pass_cnt++;
      total_cnt++; if (zero_o !== 1'b1) $display("FAIL sub_zero got=%b exp=1", zero_o); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (done_o !== 1'b0) $display("FAIL b2b_gap_done got=%b exp=0", done_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL b2b_gap_ready got=%b exp=1", ready_o); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (done_o !== 1'b1) $display("FAIL b2b_done2 got=%b exp=1", done_o); else pass_cnt++;
      valid_i = 1'b0;
   endtask

   task automatic test_logic_ops();
      logic [3:0]  ops [6] = '{4'b0010, 4'b0011, 4'b0100, 4'b0111, 4'b0101, 4'b0110};
      logic [31:0] as  [6] = '{32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hDEAD, 32'h1, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'hFF00, 32'hFF00, 32'hFF00, 32'h1234_5000, 32'd31, 32'h21};
      logic [31:0] exs [6] = '{32'hF000, 32'hFFF0, 32'h0FF0, 32'h1234_5000, 32'h8000_0000, 32'h4000_0000};
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], lat);
         total_cnt++; if (result_o !== exs[i] || lat !== 1)
            $display("FAIL logic_op%0d got=%h lat=%0d exp=%h lat=1", i, result_o, lat, exs[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_mul();
      int lat;
      run_op(4'b1000, 32'hFFFF_FFFF, 32'd2, lat);
      total_cnt++; if (lat !== 33) $display("FAIL mul_latency got=%0d exp=33", lat); else pass_cnt++;
      total_cnt++; if (result_o !== 32'hFFFF_FFFE) $display("FAIL mul_result got=%h exp=fffffffe", result_o); else pass_cnt++;
      run_op(4'b1001, 32'hFFFF_FFFF, 32'd2, lat);
      total_cnt++; if (result_o !== 32'h1 || lat !== 33) $display("FAIL mulhu_result got=%h lat=%0d exp=1 lat=33", result_o, lat); else pass_cnt++;
      run_op(4'b1000, 32'd12345, 32'd6789, lat);
      total_cnt++; if (result_o !== 32'd83810205) $display("FAIL mul_small got=%0d exp=83810205", result_o); else pass_cnt++;
   endtask

   task automatic test_div();
      int lat;
      run_op(4'b1010, 32'd100, 32'd7, lat);
      total_cnt++; if (lat !== 33) $display("FAIL divu_latency got=%0d exp=33", lat); else pass_cnt++;
      total_cnt++; if (result_o !== 32'd14) $display("FAIL divu_result got=%0d exp=14", result_o); else pass_cnt++;
      run_op(4'b1011, 32'd100, 32'd7, lat);
      total_cnt++; if (result_o !== 32'd2) $display("FAIL remu_result got=%0d exp=2", result_o); else pass_cnt++;
      run_op(4'b1010, 32'hFFFF_FFFF, 32'h1_0000, lat);
      total_cnt++; if (result_o !== 32'h0000_FFFF) $display("FAIL divu_big got=%h exp=0000ffff", result_o); else pass_cnt++;
      run_op(4'b1010, 32'd100, 32'd0, lat);
      total_cnt++; if (result_o !== 32'hFFFF_FFFF || lat !== 1) $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=1", result_o, lat); else pass_cnt++;
      run_op(4'b1011, 32'd123, 32'd0, lat);
      total_cnt++; if (result_o !== 32'd123 || lat !== 1) $display("FAIL remu_by0 got=%0d lat=%0d exp=123 lat=1", result_o, lat); else pass_cnt++;
   endtask

   task automatic test_illegal();
      int lat;
      run_op(4'b1100, 32'd9, 32'd9, lat);
      total_cnt++; if (lat !== 1) $display("FAIL illegal_latency got=%0d exp=1", lat); else pass_cnt++;
      total_cnt++; if (result_o !== 32'h0) $display("FAIL illegal_result got=%h exp=0", result_o); else pass_cnt++;
      total_cnt++; if (illegal_o !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", illegal_o); else pass_cnt++;
      total_cnt++; if (zero_o !== 1'b1) $display("FAIL illegal_zero got=%b exp=1", zero_o); else pass_cnt++;
      run_op(4'b0110, 32'h8000_0000, 32'h21, lat);
      total_cnt++; if (illegal_o !== 1'b0 || result_o !== 32'h4000_0000) $display("FAIL srl_after_illegal got=%h ill=%b exp=40000000 ill=0", result_o, illegal_o); else pass_cnt++;
   endtask

   task automatic test_flush();
      int lat;
      int dones = 0;
      run_op(4'b0000, 32'd2, 32'd3, lat);
      @(negedge clk);
      @(negedge clk);
      valid_i = 1'b1; ALU_Operation_i = 4'b1000; A_i = 32'd3; B_i = 32'd5;
      @(posedge clk);
      #1 valid_i = 1'b0;
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL flush_ready got=%b exp=1", ready_o); else pass_cnt++;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      total_cnt++; if (dones !== 0) $display("FAIL flush_no_done got=%0d exp=0", dones); else pass_cnt++;
      total_cnt++; if (result_o !== 32'd5 || zero_o !== 1'b0) $display("FAIL flush_held got=%h z=%b exp=5 z=0", result_o, zero_o); else pass_cnt++;
      // flush wins over valid in IDLE
      valid_i = 1'b1; flush_i = 1'b1; ALU_Operation_i = 4'b0000; A_i = 32'd1; B_i = 32'd1;
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0;
      total_cnt++; if (done_o !== 1'b0 || ready_o !== 1'b1) $display("FAIL flush_idle got=done%b rdy%b exp=done0 rdy1", done_o, ready_o); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat;
      @(negedge clk);
      valid_i = 1'b1; ALU_Operation_i = 4'b1000; A_i = 32'd7; B_i = 32'd9;
      @(posedge clk);
      #1 valid_i = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++; if (ready_o !== 1'b1 || done_o !== 1'b0) $display("FAIL rstmid_hs got=rdy%b done%b exp=rdy1 done0", ready_o, done_o); else pass_cnt++;
      total_cnt++; if (result_o !== 32'h0 || zero_o !== 1'b1 || illegal_o !== 1'b0)
         $display("FAIL rstmid_out got=%h z=%b ill=%b exp=0 z=1 ill=0", result_o, zero_o, illegal_o);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b0;
      run_op(4'b0000, 32'd2, 32'd3, lat);
      total_cnt++; if (result_o !== 32'd5 || lat !== 1) $display("FAIL post_reset_add got=%0d lat=%0d exp=5 lat=1", result_o, lat); else pass_cnt++;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_add();
      test_back_to_back();
      test_logic_ops();
      test_mul();
      test_div();
      test_illegal();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
